// File: rtl/dcache.sv
// Direct-mapped, write-through, no-write-allocate data cache; 2^INDEX_W lines x 4 words.
// Latency: load hit responds 1 cycle after accept, load miss 6 cycles, store 2 cycles.
// Backpressure: req_ready is high only in IDLE, so one request is in flight at a time.
// Optional DCACHE_STATS_EN adds saturating hit_cnt/miss_cnt outputs for load lookups.
module dcache #(
  parameter int INDEX_W = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic        resp_valid,
  output logic [31:0] rdata,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  localparam int LINES = 1 << INDEX_W;
  localparam int TAG_W = 28 - INDEX_W;

  typedef enum logic [1:0] {IDLE, LOOKUP, REFILL, WRITE} state_t;

  state_t state, state_nxt;

  logic [31:0]        lat_addr;
  logic [31:0]        lat_wdata;
  logic               lat_we;
  logic [1:0]         cnt;
  logic [LINES-1:0]   valid;
  logic [TAG_W-1:0]   tag_arr  [LINES];
  logic [31:0]        data_arr [LINES*4];

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   tag;
  logic [1:0]         wrd;
  logic               hit;

  // Byte-offset bits are architecturally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr[1:0];

  assign idx = lat_addr[INDEX_W+3:4];
  assign tag = lat_addr[31:INDEX_W+4];
  assign wrd = lat_addr[3:2];
  assign hit = valid[idx] && (tag_arr[idx] == tag);

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and output decode; memory port mirrors latched request unless refilling
  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    rdata      = 32'h0;
    mem_we     = 1'b0;
    mem_addr   = lat_addr;
    mem_wdata  = lat_wdata;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = LOOKUP;
      end
      LOOKUP: begin
        if (lat_we) begin
          state_nxt = WRITE;
        end else if (hit) begin
          resp_valid = 1'b1;
          rdata      = data_arr[{idx, wrd}];
          state_nxt  = IDLE;
        end else begin
          state_nxt = REFILL;
        end
      end
      REFILL: begin
        mem_addr = {lat_addr[31:4], cnt, 2'b00};
        if (cnt == 2'd3) state_nxt = LOOKUP;
      end
      WRITE: begin
        mem_we     = 1'b1;
        resp_valid = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request latch, refill word counter and line valid bits
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lat_addr  <= 32'h0;
      lat_wdata <= 32'h0;
      lat_we    <= 1'b0;
      cnt       <= 2'd0;
      valid     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_addr  <= {addr[31:2], 2'b00};
            lat_wdata <= wdata;
            lat_we    <= we;
          end
        end
        LOOKUP: begin
          if (!lat_we && !hit) begin
            // Line is being replaced: keep it invalid until the last word lands,
            // so an interrupted refill never exposes a half-filled line.
            cnt        <= 2'd0;
            valid[idx] <= 1'b0;
          end
        end
        REFILL: begin
          cnt <= cnt + 2'd1;
          if (cnt == 2'd3) valid[idx] <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Tag and data arrays: refill words, and write-through update on store hit
  always_ff @(posedge clk) begin
    if (state == REFILL) begin
      data_arr[{idx, cnt}] <= mem_rdata;
      if (cnt == 2'd3) tag_arr[idx] <= tag;
    end else if (state == WRITE && hit) begin
      data_arr[{idx, wrd}] <= lat_wdata;
    end
  end

`ifdef DCACHE_STATS_EN
  logic prev_idle;

  // Count only the first lookup of each load; the post-refill lookup is skipped
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      prev_idle <= 1'b0;
      hit_cnt   <= 32'h0;
      miss_cnt  <= 32'h0;
    end else begin
      prev_idle <= (state == IDLE);
      if (state == LOOKUP && prev_idle && !lat_we) begin
        if (hit) begin
          if (hit_cnt != 32'hFFFF_FFFF) hit_cnt <= hit_cnt + 32'd1;
        end else begin
          if (miss_cnt != 32'hFFFF_FFFF) miss_cnt <= miss_cnt + 32'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_dcache.sv
// Directed bench for dcache with a queue-based scoreboard and a negedge monitor.
// Latency is counted in cycles from the accepting edge to the response pulse.
// Requests are issued one at a time; the RAM model is combinational read, clocked write.
module tb_dcache;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] addr = 32'h0;
  logic        we = 1'b0;
  logic [31:0] wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] rdata;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  dcache #(.INDEX_W(4)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready),
    .addr(addr), .we(we), .wdata(wdata),
    .resp_valid(resp_valid), .rdata(rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Data RAM model
  logic [31:0] ram [1024];
  assign mem_rdata = ram[mem_addr[11:2]];
  always @(posedge clk) if (mem_we) ram[mem_addr[11:2]] <= mem_wdata;

  typedef struct {
    logic [31:0] rd;
    logic        is_store;
    int          lat;
    logic        miss;
    logic [31:0] a;
    logic [31:0] wd;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: tracks the in-flight request and scores each response
  logic        active = 1'b0;
  int          k = 0;
  int          we_cnt = 0;
  logic [31:0] trace [8];
  exp_t        e;

  always @(negedge clk) begin
    if (!rstn) begin
      active = 1'b0;
    end else begin
      if (active) begin
        k++;
        if (k < 8) trace[k] = mem_addr;
        if (mem_we) we_cnt++;
      end
      if (resp_valid) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_resp: got resp_valid=1, expected no response (t=%0t)", $time);
        end else begin
          e = q.pop_front();
          check("latency", k, e.lat);
          check("rdata", rdata, e.is_store ? 32'h0 : e.rd);
          check("mem_we_pulses", we_cnt, e.is_store ? 32'd1 : 32'd0);
          if (e.is_store) begin
            check("store_mem_addr", mem_addr, e.a);
            check("store_mem_wdata", mem_wdata, e.wd);
          end
          if (e.miss) begin
            for (int i = 0; i < 4; i++)
              check("refill_addr", trace[2+i], {e.a[31:4], 4'h0} + 32'(4*i));
          end
        end
        active = 1'b0;
      end else begin
        check("rdata_idle", rdata, 32'h0);
      end
      if (req_valid && req_ready) begin
        active = 1'b1;
        k = 0;
        we_cnt = 0;
      end
    end
  end

  task automatic do_req(input logic [31:0] a, input logic w, input logic [31:0] d,
                        input logic [31:0] exp_rd, input int lat, input logic miss);
    exp_t x;
    int n;
    x.rd = exp_rd; x.is_store = w; x.lat = lat; x.miss = miss;
    x.a = {a[31:2], 2'b00}; x.wd = d;
    q.push_back(x);
    @(posedge clk); #1;
    req_valid = 1'b1; addr = a; we = w; wdata = d;
    @(posedge clk); #1;
    // Garbage on the inputs while busy must be ignored
    req_valid = 1'b0; addr = 32'hFFFF_FFF0; we = ~w; wdata = 32'hBAD0_BAD0;
    n = 0;
    while (q.size() != 0 && n < 30) begin
      @(posedge clk);
      n++;
    end
    if (q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL timeout: got no response for addr 0x%0h, expected one within 30 cycles", a);
      q.delete();
    end
    #1;
  endtask

  task automatic check_reset_outputs();
    check("rst_resp_valid", resp_valid, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_mem_we", mem_we, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 32'h5000_0000 + 32'(i * 4);
    ram[32'h40 >> 2] = 32'hDEAD_BEEF;

    #12;
    check_reset_outputs();
    @(negedge clk); rstn = 1'b1; #1;
    check("rst_req_ready", req_ready, 32'h1);
    check_reset_outputs();

    do_req(32'h40,  1'b0, 32'h0,         32'hDEAD_BEEF, 6, 1'b1); // cold miss, refill 0x40..0x4C
    do_req(32'h44,  1'b0, 32'h0,         32'h5000_0044, 1, 1'b0); // hit
    do_req(32'h48,  1'b1, 32'h1234_5678, 32'h0,         2, 1'b0); // store hit
    do_req(32'h48,  1'b0, 32'h0,         32'h1234_5678, 1, 1'b0); // cached word updated
    do_req(32'h0,   1'b0, 32'h0,         32'h5000_0000, 6, 1'b1); // fill line 0
    do_req(32'h400, 1'b1, 32'hCAFE_F00D, 32'h0,         2, 1'b0); // store miss, RAM only
    check("ram_store_miss", ram[32'h400 >> 2], 32'hCAFE_F00D);
    do_req(32'h0,   1'b0, 32'h0,         32'h5000_0000, 1, 1'b0); // line 0 untouched
    do_req(32'h400, 1'b0, 32'h0,         32'hCAFE_F00D, 6, 1'b1); // conflict miss
    do_req(32'h4,   1'b0, 32'h0,         32'h5000_0004, 6, 1'b1); // evicted again
    do_req(32'h40B, 1'b0, 32'h0,         32'h5000_0408, 6, 1'b1); // low bits ignored
    do_req(32'h4C,  1'b0, 32'h0,         32'h5000_004C, 1, 1'b0); // line 4 still resident

    // Abort a refill with reset while the word counter is 2
    @(posedge clk); #1;
    req_valid = 1'b1; addr = 32'h80; we = 1'b0; wdata = 32'h0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("refill_cnt2_addr", mem_addr, 32'h88);
    rstn = 1'b0; #1;
    check_reset_outputs();
    @(negedge clk); rstn = 1'b1; #1;
    check("rst_req_ready", req_ready, 32'h1);
    check_reset_outputs();

    do_req(32'h80, 1'b0, 32'h0, 32'h5000_0080, 6, 1'b1); // aborted line refilled in full
    do_req(32'h40, 1'b0, 32'h0, 32'hDEAD_BEEF, 6, 1'b1); // reset invalidated line 4
    do_req(32'h48, 1'b0, 32'h0, 32'h1234_5678, 1, 1'b0); // store reached RAM earlier

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dcache.md
DCACHE -- requirements
Module: dcache

Interface
REQ-001 Parameter: INDEX_W, 4, line-index width; cache holds 2^INDEX_W lines of 4 words (16 bytes) each.
REQ-002 Clock and reset SHALL be one clock and an asynchronous, active-low reset: clk input 1, system clock, all state on rising edge.
REQ-003 rstn  input  1  asynchronous active-low reset.
REQ-004 req_valid  input  1  CPU data request valid.
REQ-005 req_ready  output  1  cache accepts a request.
REQ-006 addr  input  32  byte address, word-aligned; bits [1:0] ignored.
REQ-007 we  input  1  1 = store word, 0 = load word.
REQ-008 wdata  input  32  store data.
REQ-009 resp_valid  output  1  one-cycle pulse: load data valid or store complete.
REQ-010 rdata  output  32  load data, valid only with resp_valid on a load.
REQ-011 mem_addr  output  32  byte address to data RAM, word-aligned.
REQ-012 mem_we  output  1  data RAM write enable.
REQ-013 mem_wdata  output  32  data RAM write data.
REQ-014 mem_rdata  input  32  data RAM combinational read data for mem_addr.

Function
REQ-015 Organisation SHALL be direct-mapped, write-through, no-write-allocate; tag = addr[31:INDEX_W+4], index = addr[INDEX_W+3:4], word = addr[3:2].
REQ-016 FSM states SHALL be IDLE, LOOKUP, REFILL, WRITE; req_ready = 1 only in IDLE.
REQ-017 IDLE: on req_valid & req_ready, addr/we/wdata are latched at that edge (E0) and state -> LOOKUP; inputs are ignored at all other times.
REQ-018 LOOKUP: hit = valid[index] & (tag[index] == latched tag); invalid line is a miss regardless of tag bits.
REQ-019 LOOKUP, load hit: resp_valid = 1 and rdata = cached word during this cycle; -> IDLE (response in cycle after E0).
REQ-020 LOOKUP, load miss: word counter cleared to 0; -> REFILL.
REQ-021 LOOKUP, store (hit or miss): -> WRITE.
REQ-022 REFILL: mem_addr = {latched tag, index, counter, 2'b00}; mem_rdata written to line word counter each edge; counter increments 0..3.
REQ-023 REFILL at counter == 3: tag written, valid set, counter wraps to 0, -> LOOKUP (guaranteed hit); load-miss response in cycle after E5.
REQ-024 WRITE: mem_we = 1, mem_addr = latched addr, mem_wdata = latched wdata, resp_valid = 1; on hit the cached word is updated at the same edge; on miss cache unchanged; -> IDLE (store response in cycle after E1).
REQ-025 Outside WRITE mem_we = 0; outside REFILL/WRITE mem_addr = latched addr (0 after reset); mem_wdata = latched wdata.
REQ-026 rdata SHALL be 0 whenever resp_valid = 0 or the response is a store.
REQ-027 Back-to-back requests: next request accepted no earlier than the IDLE cycle following a response.

Reset
REQ-028 rstn low at any time, including mid-REFILL or WRITE, SHALL immediately force IDLE, clear all valid bits, counter and latched fields to 0; outputs: req_ready = 1 after reset release, resp_valid = 0, rdata = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
REQ-029 A refill aborted by reset SHALL leave its line invalid; data arrays need no reset.

Configuration
REQ-030 Macro DCACHE_STATS_EN: when defined, outputs hit_cnt (32) and miss_cnt (32) exist, each reset to 0, incremented once per LOOKUP of a new request (not the post-refill LOOKUP), saturating at 0xFFFFFFFF; when undefined, these ports and counters are absent and behaviour is otherwise identical.

Verification
REQ-031 Reset, then load addr 0x0000_0040 with RAM word 0x40 = 0xDEAD_BEEF -> mem_addr sequence 0x40,0x44,0x48,0x4C, resp_valid in cycle after E5, rdata 0xDEAD_BEEF.
REQ-032 Repeat load 0x0000_0044 -> resp_valid in cycle after E0, no mem_addr change to refill addresses, rdata = RAM word 0x44.
REQ-033 Store 0x1234_5678 to 0x0000_0048 (line resident) -> mem_we pulse with mem_addr 0x48, ack cycle after E1; subsequent load 0x48 hits returning 0x1234_5678.
REQ-034 Store to non-resident 0x0000_0400 then load 0x0000_0400 -> store writes RAM only; load misses and refills (INDEX_W = 4, line 0 conflicts with 0x0).
REQ-035 Assert rstn low during REFILL counter = 2, release, load same address -> full 4-word refill again, correct data.
REQ-036 With DCACHE_STATS_EN, run REQ-031..033 -> hit_cnt = 2, miss_cnt = 1.
